bcd_updown_display: RTL
=======================

Name: bcd_updown_display

Overview:
- Parametrised successor to the two-digit counter/display block.
- N-digit BCD up/down counter driven by push-button inputs, with per-digit 7-segment decode.
- Adds beyond the two-digit block: input synchronisation, edge detection, hold-to-auto-repeat FSM, parallel load, selectable wrap/saturate at a programmable maximum, wrap event pulse.
- Sits between board buttons/switches and the 7-segment display pins.

Parameters:
- DIGITS, 2, number of BCD digits/displays (1..4).
- MAX_VALUE, 99, upper count limit in decimal; must be <= 10^DIGITS-1.
- WRAP, 1, 1 = wrap MAX_VALUE<->0; 0 = saturate at 0 and MAX_VALUE.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (common anode).
- REPEAT_DELAY, 0, cycles of hold before first auto-repeat step; 0 disables auto-repeat.
- REPEAT_PERIOD, 1, cycles between subsequent auto-repeat steps (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- increment  in  1  raw up button, asynchronous to clk.
- decrease  in  1  raw down button, asynchronous to clk.
- load  in  1  synchronous parallel load strobe, level-sensitive.
- load_value  in  4*DIGITS  BCD value to load; digit 0 in [3:0].
- count_bcd  out  4*DIGITS  current count, BCD; digit 0 (units) in [3:0].
- display_out  out  7*DIGITS  segments; digit k in [7k+6:7k], bit order g,f,e,d,c,b,a (MSB..LSB).
- wrap_pulse  out  1  one-cycle pulse when count wraps in either direction.

Behaviour:
- Reset (reset=0, async): count_bcd=0, wrap_pulse=0, synchronisers cleared to 0, FSM=IDLE. display_out shows "0" on every digit (0x40 per digit active-low, 0x3F active-high).
- increment/decrease: two-flop synchroniser each; rising edge detected on the synchronised signal.
- Latency: input high before clk edge 1 -> count_bcd updates on edge 3.
- display_out is combinational decode of count_bcd: zero added latency. Codes are outside 0-9 never occur.
- Step resolution, in priority order, each cycle:
  - load=1: count_bcd <= load_value. Any digit >9 or value > MAX_VALUE loads MAX_VALUE. Pending steps ignored, FSM -> IDLE, no wrap_pulse.
  - up and down steps requested in the same cycle: no change.
  - up at MAX_VALUE: WRAP=1 -> 0 with wrap_pulse=1; WRAP=0 -> hold.
  - down at 0: WRAP=1 -> MAX_VALUE with wrap_pulse=1; WRAP=0 -> hold.
  - Otherwise ±1 with per-digit BCD carry/borrow (e.g. 09->10, 10->09, 199->200).
- wrap_pulse: registered, high for exactly the cycle after the wrapping update.
- Auto-repeat FSM, active when REPEAT_DELAY>0, states IDLE, DELAY, REPEAT:
  - IDLE: exactly one synchronised button rises -> issue one step, load timer=REPEAT_DELAY, go DELAY.
  - DELAY: same button still high -> decrement timer; timer expiry -> issue step, timer=REPEAT_PERIOD, go REPEAT.
  - REPEAT: step every REPEAT_PERIOD cycles while held.
  - In DELAY or REPEAT: held button released, or other button asserted -> IDLE, no step.
  - REPEAT_DELAY=0: FSM stays IDLE; one step per rising edge only.
- Reset mid-operation aborts FSM and timer. A button still held when reset deasserts shows a rising edge after synchronisation and produces one step.
- load held high: count tracks load_value every cycle; button edges are lost.

Test Plan:
- Reset release, no buttons (DIGITS=2, SEG_ACTIVE_LOW=1) -> count_bcd=0x00, display_out=14'h2040, wrap_pulse=0.
- Pulse increment 10 times (each >=3 cycles high, >=3 low) -> count_bcd=0x10, digit1=7'b1111001, digit0=7'b1000000. Then one decrease -> 0x09.
- WRAP=1, MAX_VALUE=99, load 0x99 then one increment -> count_bcd=0x00, single-cycle wrap_pulse. One decrease -> 0x99 with wrap_pulse. Repeat with WRAP=0 -> stays 0x99 / 0x00, no pulse.
- load_value=0xA5 with load=1 one cycle -> count_bcd=0x99. MAX_VALUE=59, load 0x75 -> 0x59.
- REPEAT_DELAY=8, REPEAT_PERIOD=4, hold increment 30 cycles from 0 -> one step at edge, then steps at +8, +12, +16, +20, +24, +28 -> final 0x07. Assert decrease mid-hold -> stepping stops at IDLE.
- Both buttons rise same cycle -> no change. reset pulse during REPEAT with increment held -> 0x00, then exactly one step after release -> 0x01.

Source files
------------

// File: rtl/bcd_updown_display.sv
// N-digit BCD up/down counter fed by raw push buttons, with hold-to-repeat,
// parallel load, wrap/saturate at MAX_VALUE and per-digit 7-segment decode.
module bcd_updown_display #(
    parameter int DIGITS         = 2,
    parameter int MAX_VALUE      = 99,
    parameter int WRAP           = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int REPEAT_DELAY   = 0,
    parameter int REPEAT_PERIOD  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                increment,
    input  logic                decrease,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic [7*DIGITS-1:0] display_out,
    output logic                wrap_pulse
);

    localparam int DATA_W  = 4 * DIGITS;
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    function automatic logic [DATA_W-1:0] int_to_bcd(input int value);
        logic [DATA_W-1:0] bcd;
        int                rem;
        bcd = '0;
        rem = value;
        for (int k = 0; k < DIGITS; k++) begin
            bcd[4*k +: 4] = 4'(rem % 10);
            rem           = rem / 10;
        end
        return bcd;
    endfunction

    localparam logic [DATA_W-1:0] MAX_BCD = int_to_bcd(MAX_VALUE);

    function automatic logic [DATA_W-1:0] bcd_inc(input logic [DATA_W-1:0] value);
        logic [DATA_W-1:0] res;
        logic              carry;
        res   = value;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (value[4*k +: 4] == 4'd9) begin
                    res[4*k +: 4] = 4'd0;
                end else begin
                    res[4*k +: 4] = value[4*k +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] bcd_dec(input logic [DATA_W-1:0] value);
        logic [DATA_W-1:0] res;
        logic              borrow;
        res    = value;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (value[4*k +: 4] == 4'd0) begin
                    res[4*k +: 4] = 4'd9;
                end else begin
                    res[4*k +: 4] = value[4*k +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Packed BCD compares like its decimal value once every digit is 0-9.
    function automatic logic [DATA_W-1:0] load_clamp(input logic [DATA_W-1:0] value);
        logic bad;
        bad = (value > MAX_BCD);
        for (int k = 0; k < DIGITS; k++) begin
            if (value[4*k +: 4] > 4'd9) bad = 1'b1;
        end
        return bad ? MAX_BCD : value;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
    endfunction

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic              inc_p0, inc_p1, inc_p2;
    logic              dec_p0, dec_p1, dec_p2;
    logic              inc_rise, dec_rise;
    state_t            state, state_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic              dir_up, dir_up_nxt;
    logic              held;
    logic              step_up, step_dn;
    logic [DATA_W-1:0] count_nxt;
    logic              wrap_nxt;

    // Stage p0/p1: two-flop synchronisers; p2 holds the previous synchronised level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc_p0 <= 1'b0;
            inc_p1 <= 1'b0;
            inc_p2 <= 1'b0;
            dec_p0 <= 1'b0;
            dec_p1 <= 1'b0;
            dec_p2 <= 1'b0;
        end else begin
            inc_p0 <= increment;
            inc_p1 <= inc_p0;
            inc_p2 <= inc_p1;
            dec_p0 <= decrease;
            dec_p1 <= dec_p0;
            dec_p2 <= dec_p1;
        end
    end

    assign inc_rise = inc_p1 & ~inc_p2;
    assign dec_rise = dec_p1 & ~dec_p2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            timer  <= '0;
            dir_up <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            dir_up <= dir_up_nxt;
        end
    end

    // Held means the tracked button is still high and the other one is not.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        dir_up_nxt = dir_up;
        held       = 1'b0;
        step_up    = 1'b0;
        step_dn    = 1'b0;
        if (REPEAT_DELAY == 0) begin
            step_up   = inc_rise;
            step_dn   = dec_rise;
            state_nxt = IDLE;
        end else if (load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (inc_rise ^ dec_rise) begin
                        step_up    = inc_rise;
                        step_dn    = dec_rise;
                        dir_up_nxt = inc_rise;
                        timer_nxt  = TMR_W'(REPEAT_DELAY);
                        state_nxt  = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    held = dir_up ? (inc_p1 & ~dec_p1) : (dec_p1 & ~inc_p1);
                    if (!held) begin
                        state_nxt = IDLE;
                    end else if (timer == TMR_W'(1)) begin
                        step_up   = dir_up;
                        step_dn   = ~dir_up;
                        timer_nxt = TMR_W'(REPEAT_PERIOD);
                        state_nxt = REPEAT;
                    end else begin
                        timer_nxt = timer - TMR_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        count_nxt = count_bcd;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = load_clamp(load_value);
        end else if (step_up && !step_dn) begin
            if (count_bcd == MAX_BCD) begin
                if (WRAP != 0) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                count_nxt = bcd_inc(count_bcd);
            end
        end else if (step_dn && !step_up) begin
            if (count_bcd == '0) begin
                if (WRAP != 0) begin
                    count_nxt = MAX_BCD;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                count_nxt = bcd_dec(count_bcd);
            end
        end
    end

    // Stage p3: count register and registered wrap event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_bcd  <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            count_bcd  <= count_nxt;
            wrap_pulse <= wrap_nxt;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_seg
        assign display_out[7*k +: 7] = seg_decode(count_bcd[4*k +: 4]);
    end

endmodule
